// File: rtl/uart_button_tx_if.sv
// Request/line bundle between a byte source and the button-driven UART TX.
// The master raises tx_start and the slave drives the serial line and status.
interface uart_button_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_serial,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_serial,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_button_tx.sv
// 8N1 UART transmitter, LSB first, one frame per tx_start rising edge.
// All outputs registered; spare state codes fall back to idle.
module uart_button_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_WIDTH    = 16
) (
  input  logic             clock,
  input  logic             reset,
  uart_button_tx_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [CNT_WIDTH-1:0] ONE =
    CNT_WIDTH'(1);

  state_e               state_q;
  logic [CNT_WIDTH-1:0] clk_cnt_q;
  logic [2:0]           bit_idx_q;
  logic [7:0]           shift_q;
  logic                 start_prev_q;
  logic                 tx_serial_q;
  logic                 tx_busy_q;
  logic                 tx_done_q;

  logic accept;
  logic bit_end;

  assign accept  = bus.tx_start & ~start_prev_q
                 & (state_q == S_IDLE);
  assign bit_end = (clk_cnt_q == LAST);

  assign bus.tx_serial = tx_serial_q;
  assign bus.tx_busy   = tx_busy_q;
  assign bus.tx_done   = tx_done_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      // High so a request already asserted at release is not an edge
      start_prev_q <= 1'b1;
      tx_serial_q  <= 1'b1;
      tx_busy_q    <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      start_prev_q <= bus.tx_start;
      tx_done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_serial_q <= 1'b1;
          tx_busy_q   <= 1'b0;
          if (accept) begin
            shift_q     <= bus.tx_data;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            state_q     <= S_START;
            tx_serial_q <= 1'b0;
            tx_busy_q   <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            state_q     <= S_DATA;
            tx_serial_q <= shift_q[0];
          end else begin
            clk_cnt_q <= clk_cnt_q + ONE;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            shift_q   <= {1'b0, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_q     <= S_STOP;
              tx_serial_q <= 1'b1;
            end else begin
              bit_idx_q   <= bit_idx_q + 3'd1;
              tx_serial_q <= shift_q[1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + ONE;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            state_q   <= S_IDLE;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b1;
          end else begin
            clk_cnt_q <= clk_cnt_q + ONE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          clk_cnt_q   <= '0;
          bit_idx_q   <= '0;
          tx_serial_q <= 1'b1;
          tx_busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_button_tx.md
Name: uart_button_tx

Overview:
UART transmitter, 8N1, LSB first, idle-high line. Sends one byte per rising edge of a level request.
The request is normally the debounced switch level, so one press sends exactly one byte regardless of hold time.
Sits between the switch debouncer and the board TX pin. Also usable standalone from any level or pulse request source.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
CNT_WIDTH, 16, width of the bit-period counter; must satisfy 2^CNT_WIDTH > CLKS_PER_BIT.

Ports:
clock      input   1  system clock, all logic on rising edge
reset      input   1  asynchronous, active-low reset
tx_start   input   1  send request, level; acts only on its 0->1 transition
tx_data    input   8  byte to send; sampled on the accepting edge only
tx_serial  output  1  serial line; 1 = idle/mark
tx_busy    output  1  high while a frame is in progress
tx_done    output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset state:
  - tx_serial=1, tx_busy=0, tx_done=0, state=IDLE, counters=0, shift register=0.
  - start_prev=1, so a request already high at reset release does not trigger.
- Edge detect: start_prev <= tx_start every cycle; accept = tx_start & ~start_prev & (state==IDLE).
- States:
  - IDLE: tx_serial=1, tx_busy=0. On accept, latch tx_data into shift register, clear counters, go to START.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx_serial=shift[0] for CLKS_PER_BIT cycles per bit; at each bit end shift right and increment bit_idx. After bit 7 ends, go to STOP.
  - STOP: tx_serial=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse tx_done for exactly that one cycle.
- Bit period: clk_cnt counts 0..CLKS_PER_BIT-1; a period ends when clk_cnt==CLKS_PER_BIT-1, then clk_cnt wraps to 0.
- Registered outputs: tx_serial, tx_busy and tx_done come from flops, no combinational paths from inputs.
- Timing:
  - Accepting edge at clock cycle N (tx_start=1, start_prev=0).
  - From cycle N+1: tx_serial=0 and tx_busy=1.
  - Frame lasts exactly 10*CLKS_PER_BIT cycles; tx_busy falls and tx_done pulses at cycle N+1+10*CLKS_PER_BIT.
- Rising edges of tx_start while busy are ignored, not queued. tx_data changes while busy do not affect the frame in flight.
- tx_start held high across frame end does not retrigger; it must go low then high again.
- Back-to-back: a rising edge in the cycle tx_done pulses (state already IDLE) is accepted; the next start bit begins the following cycle, so the minimum idle gap is 1 cycle.
- Reset asserted mid-frame: immediately (asynchronously) tx_serial=1, tx_busy=0, no tx_done, frame abandoned.
- Illegal states (3-bit encoding has spare codes): recover to IDLE with tx_serial=1.

Test Plan:
(all with CLKS_PER_BIT=4)
1. Reset, then tx_data=8'hA5, tx_start 0->1 -> line: 0 (4 cyc), then bits 1,0,1,0,0,1,0,1 (4 cyc each), then 1 (4 cyc). tx_busy high 40 cycles; tx_done 1 cycle at N+41.
2. Hold tx_start high 200 cycles with tx_data=8'h3C -> exactly one frame (bits 0,0,1,1,1,1,0,0), then line stays 1.
3. During an 8'h0F frame, toggle tx_start twice and change tx_data to 8'hFF -> frame carries 8'h0F unchanged, no second frame starts.
4. Raise tx_start in the tx_done cycle with tx_data=8'h81 -> second start bit begins next cycle; frames are exactly 41 cycles apart start-to-start.
5. tx_start=1 while reset low, then release reset -> no frame; later drop low and raise again -> a frame is sent.
6. Assert reset at cycle 17 of an 8'h55 frame -> tx_serial=1 and tx_busy=0 immediately, no tx_done; a fresh request after release sends a complete 8'h55 frame.
